sphincs_digest_split: RTL

Consumer of the 34-byte SPHINCS+-SHA256-128f message digest H_msg. It accepts one digest via a valid/ready handshake and latches the hypertree tree index and leaf index. It then streams the 33 FORS leaf indices, one per handshake, to the FORS signing/verification datapath. It sits directly downstream of the H_msg producer and upstream of the FORS and hypertree engines.

---
 rtl/sphincs_digest_split.sv | 91 +++++++++
 1 files changed

// File: rtl/sphincs_digest_split.sv
// Splits an H_msg digest into hypertree tree/leaf indices and streams the K FORS indices.
// Latency: FORS index 0 one cycle after accept; done pulses one cycle after the last transfer; fors_ready stalls the stream in place.
module sphincs_digest_split #(
  parameter int K         = 33,
  parameter int A         = 6,
  parameter int TREE_BITS = 63,
  parameter int LEAF_BITS = 3
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [271:0]           H_msg,
  output logic [TREE_BITS-1:0]   idx_tree,
  output logic [LEAF_BITS-1:0]   idx_leaf,
  output logic                   fors_valid,
  input  logic                   fors_ready,
  output logic [A-1:0]           fors_idx,
  output logic [$clog2(K)-1:0]   fors_num,
  output logic                   fors_last,
  output logic                   done
);

  localparam int MD_BITS = K * A;
  localparam int CNT_W   = $clog2(K);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]           r_state;
  logic [MD_BITS-1:0]   r_sr;
  logic [CNT_W-1:0]     r_cnt;
  logic [TREE_BITS-1:0] r_tree;
  logic [LEAF_BITS-1:0] r_leaf;

  logic w_accept;
  logic w_xfer;
  logic w_last;
  logic w_unused;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = (r_cnt == CNT_W'(K - 1));
  assign w_xfer   = (r_state == S_STREAM) && fors_ready;
  // Padding bits of md, the masked tree MSB and the unused leaf-byte bits.
  assign w_unused = &{1'b0, H_msg[73:71], H_msg[7:3]};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_tree  <= '0;
      r_leaf  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sr    <= H_msg[271 -: MD_BITS];
            r_tree  <= H_msg[8 +: TREE_BITS];
            r_leaf  <= H_msg[LEAF_BITS-1:0];
            r_cnt   <= '0;
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_xfer) begin
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_sr  <= {r_sr[MD_BITS-A-1:0], {A{1'b0}}};
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign fors_valid = (r_state == S_STREAM);
  assign fors_idx   = r_sr[MD_BITS-1 -: A];
  assign fors_num   = r_cnt;
  assign fors_last  = fors_valid && w_last;
  assign done       = (r_state == S_DONE);
  assign idx_tree   = r_tree;
  assign idx_leaf   = r_leaf;

endmodule
